// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes and the command sequencer state encoding.
package axi_lite_pkg;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespExOkay = 2'b01;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [2:0] {
    StIdle       = 3'd0,
    StRdAddr     = 3'd1,
    StRdData     = 3'd2,
    StWrAddrData = 3'd3,
    StWrResp     = 3'd4,
    StRsp        = 3'd5
  } seq_state_e;

endpackage

// File: rtl/axi_lite_timeout_ctr.sv
// Wait-state watchdog: counts enabled cycles since the last clear and flags expiry at TIMEOUT-1.
module axi_lite_timeout_ctr #(
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [CNT_W-1:0] Limit = (TIMEOUT == 0) ? '0 : CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // TIMEOUT of zero disables the watchdog entirely.
  assign expire = (TIMEOUT != 0) && enable && (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && !expire) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_lite_cmd_sequencer.sv
// Single-outstanding command sequencer driving an AXI-Lite master's request inputs and enables,
// returning one response (data, RESP, timeout) per accepted command.
module axi_lite_cmd_sequencer
  import axi_lite_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 256,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_resp,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] mread_address,
  output logic [ADDR_W-1:0] mwrite_address,
  output logic [DATA_W-1:0] mwrite_data,
  output logic              rdaddr_enb,
  output logic              wraddr_enb,
  output logic              wrdata_enb,
  input  logic              ARVALID,
  input  logic              ARREADY,
  input  logic              RVALID,
  input  logic              RREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              AWVALID,
  input  logic              AwREADY,
  input  logic              WVALID,
  input  logic              WREADY,
  input  logic              BVALID,
  input  logic              BREADY,
  input  logic [1:0]        BRESP
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d, wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d, rdata_q, rdata_d;
  logic [1:0]        resp_q, resp_d;
  logic              timeout_q, timeout_d;
  logic              rd_en_q, rd_en_d, wa_en_q, wa_en_d, wd_en_q, wd_en_d;
  logic              aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic              aw_fire, w_fire, abort;
  logic              ctr_clear, ctr_enable, expire;

  assign ctr_enable = (state_q == StRdAddr) || (state_q == StRdData) ||
                      (state_q == StWrAddrData) || (state_q == StWrResp);
  // Any state change restarts the count, so every wait state begins from zero.
  assign ctr_clear  = (state_d != state_q);

  axi_lite_timeout_ctr #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timeout_ctr (
    .clk    (clk),
    .rst    (rst),
    .clear  (ctr_clear),
    .enable (ctr_enable),
    .expire (expire)
  );

  assign aw_fire = AWVALID && AwREADY && !aw_done_q;
  assign w_fire  = WVALID && WREADY && !w_done_q;

  always_comb begin
    state_d   = state_q;
    rd_addr_d = rd_addr_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rdata_d   = rdata_q;
    resp_d    = resp_q;
    timeout_d = timeout_q;
    rd_en_d   = rd_en_q;
    wa_en_d   = wa_en_q;
    wd_en_d   = wd_en_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    abort     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            wr_addr_d = cmd_addr;
            wr_data_d = cmd_wdata;
            wa_en_d   = 1'b1;
            wd_en_d   = 1'b1;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = StWrAddrData;
          end else begin
            rd_addr_d = cmd_addr;
            rd_en_d   = 1'b1;
            state_d   = StRdAddr;
          end
        end
      end
      StRdAddr: begin
        if (ARVALID && ARREADY) begin
          rd_en_d = 1'b0;
          state_d = StRdData;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      StRdData: begin
        if (RVALID && RREADY) begin
          rdata_d = RDATA;
          resp_d  = RRESP;
          state_d = StRsp;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      StWrAddrData: begin
        if (aw_fire) begin
          aw_done_d = 1'b1;
          wa_en_d   = 1'b0;
        end
        if (w_fire) begin
          w_done_d = 1'b1;
          wd_en_d  = 1'b0;
        end
        if (aw_done_d && w_done_d) begin
          state_d = StWrResp;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      StWrResp: begin
        if (BVALID && BREADY) begin
          rdata_d = '0;
          resp_d  = BRESP;
          state_d = StRsp;
        end else if (expire) begin
          abort = 1'b1;
        end
      end
      StRsp: begin
        if (rsp_ready) begin
          timeout_d = 1'b0;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      rd_en_d   = 1'b0;
      wa_en_d   = 1'b0;
      wd_en_d   = 1'b0;
      rdata_d   = '0;
      resp_d    = RespSlvErr;
      timeout_d = 1'b1;
      state_d   = StRsp;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rdata_q   <= '0;
      resp_q    <= RespOkay;
      timeout_q <= 1'b0;
      rd_en_q   <= 1'b0;
      wa_en_q   <= 1'b0;
      wd_en_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      rd_addr_q <= rd_addr_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rdata_q   <= rdata_d;
      resp_q    <= resp_d;
      timeout_q <= timeout_d;
      rd_en_q   <= rd_en_d;
      wa_en_q   <= wa_en_d;
      wd_en_q   <= wd_en_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  assign cmd_ready      = (state_q == StIdle);
  assign rsp_valid      = (state_q == StRsp);
  assign rsp_rdata      = rdata_q;
  assign rsp_resp       = resp_q;
  assign rsp_timeout    = timeout_q;
  assign mread_address  = rd_addr_q;
  assign mwrite_address = wr_addr_q;
  assign mwrite_data    = wr_data_q;
  assign rdaddr_enb     = rd_en_q;
  assign wraddr_enb     = wa_en_q;
  assign wrdata_enb     = wd_en_q;

endmodule

// File: tb/tb_axi_lite_cmd_sequencer.sv
// Scoreboard bench for axi_lite_cmd_sequencer: emulates the AXI-Lite handshakes by hand.
module tb_axi_lite_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] mread_address, mwrite_address, mwrite_data;
  logic        rdaddr_enb, wraddr_enb, wrdata_enb;
  logic        ARVALID, ARREADY, RVALID, RREADY, AWVALID, AwREADY, WVALID, WREADY;
  logic        BVALID, BREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP, BRESP;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
  } rsp_t;

  rsp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   aw_rise = 0, w_rise = 0;
  logic aw_prev = 1'b0, w_prev = 1'b0;

  always #5 clk = ~clk;

  axi_lite_cmd_sequencer #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .TIMEOUT (8),
    .CNT_W   (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_wdata      (cmd_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rdata      (rsp_rdata),
    .rsp_resp       (rsp_resp),
    .rsp_timeout    (rsp_timeout),
    .mread_address  (mread_address),
    .mwrite_address (mwrite_address),
    .mwrite_data    (mwrite_data),
    .rdaddr_enb     (rdaddr_enb),
    .wraddr_enb     (wraddr_enb),
    .wrdata_enb     (wrdata_enb),
    .ARVALID        (ARVALID),
    .ARREADY        (ARREADY),
    .RVALID         (RVALID),
    .RREADY         (RREADY),
    .RDATA          (RDATA),
    .RRESP          (RRESP),
    .AWVALID        (AWVALID),
    .AwREADY        (AwREADY),
    .WVALID         (WVALID),
    .WREADY         (WREADY),
    .BVALID         (BVALID),
    .BREADY         (BREADY),
    .BRESP          (BRESP)
  );

  // Rising edges of the write enables = number of requests a master would launch.
  always @(negedge clk) begin
    if (wraddr_enb && !aw_prev) aw_rise++;
    if (wrdata_enb && !w_prev) w_rise++;
    aw_prev = wraddr_enb;
    w_prev  = wrdata_enb;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = data;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic ar_hs();
    ARVALID = 1'b1; ARREADY = 1'b1;
    tick();
    ARVALID = 1'b0; ARREADY = 1'b0;
  endtask

  task automatic r_hs(input logic [31:0] data, input logic [1:0] resp);
    RVALID = 1'b1; RREADY = 1'b1; RDATA = data; RRESP = resp;
    tick();
    RVALID = 1'b0; RREADY = 1'b0; RDATA = '0; RRESP = 2'b00;
  endtask

  task automatic b_hs(input logic [1:0] resp);
    BVALID = 1'b1; BREADY = 1'b1; BRESP = resp;
    tick();
    BVALID = 1'b0; BREADY = 1'b0; BRESP = 2'b00;
  endtask

  task automatic push(input logic [31:0] d, input logic [1:0] r, input logic t);
    rsp_t e;
    e.rdata = d;
    e.resp  = r;
    e.to    = t;
    exp_q.push_back(e);
  endtask

  task automatic collect_rsp(input string tag);
    rsp_t e;
    int   n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check({tag, "_rsp_valid"}, rsp_valid, 1);
    check({tag, "_sb_nonempty"}, exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_rdata"}, rsp_rdata, e.rdata);
      check({tag, "_resp"}, rsp_resp, e.resp);
      check({tag, "_timeout"}, rsp_timeout, e.to);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check({tag, "_rsp_drop"}, rsp_valid, 0);
    check({tag, "_cmd_ready_back"}, cmd_ready, 1);
    check({tag, "_timeout_clear"}, rsp_timeout, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    {cmd_valid, cmd_write, rsp_ready} = '0;
    cmd_addr = '0; cmd_wdata = '0;
    {ARVALID, ARREADY, RVALID, RREADY, AWVALID, AwREADY, WVALID, WREADY, BVALID, BREADY} = '0;
    RDATA = '0; RRESP = '0; BRESP = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_enables", {rdaddr_enb, wraddr_enb, wrdata_enb}, 0);
    check("rst_addr", mread_address, 0);
    rst = 1'b1;
    tick();

    // Read with OKAY response.
    check("rd_enb_pre", rdaddr_enb, 0);
    issue(1'b0, 32'h0000_0010, 32'h0);
    push(32'hDEAD_BEEF, 2'b00, 1'b0);
    check("rd_enb_on", rdaddr_enb, 1);
    check("rd_addr", mread_address, 32'h10);
    check("rd_cmd_ready", cmd_ready, 0);
    ar_hs();
    check("rd_enb_off", rdaddr_enb, 0);
    r_hs(32'hDEAD_BEEF, 2'b00);
    collect_rsp("rd");

    // Write, W accepted two cycles before AW, SLVERR response.
    aw_rise = 0; w_rise = 0;
    issue(1'b1, 32'h20, 32'h1234_5678);
    check("wr_enbs_on", {wraddr_enb, wrdata_enb}, 2'b11);
    check("wr_addr", mwrite_address, 32'h20);
    check("wr_data", mwrite_data, 32'h1234_5678);
    WVALID = 1'b1; WREADY = 1'b1;
    tick();
    WVALID = 1'b0; WREADY = 1'b0;
    check("wfirst_enbs", {wraddr_enb, wrdata_enb}, 2'b10);
    tick();
    check("wfirst_hold", {wraddr_enb, wrdata_enb}, 2'b10);
    AWVALID = 1'b1; AwREADY = 1'b1;
    tick();
    AWVALID = 1'b0; AwREADY = 1'b0;
    check("wfirst_both_off", {wraddr_enb, wrdata_enb}, 2'b00);
    tick();
    push(32'h0, 2'b10, 1'b0);
    b_hs(2'b10);
    collect_rsp("wfirst");
    check("wfirst_aw_once", aw_rise, 1);
    check("wfirst_w_once", w_rise, 1);

    // Simultaneous AW and W handshake: WR_RESP on the very next cycle.
    aw_rise = 0; w_rise = 0;
    issue(1'b1, 32'h30, 32'hA5A5_A5A5);
    AWVALID = 1'b1; AwREADY = 1'b1; WVALID = 1'b1; WREADY = 1'b1;
    tick();
    {AWVALID, AwREADY, WVALID, WREADY} = '0;
    check("sim_enbs_off", {wraddr_enb, wrdata_enb}, 2'b00);
    push(32'h0, 2'b00, 1'b0);
    b_hs(2'b00);
    check("sim_rsp_next", rsp_valid, 1);
    collect_rsp("sim");
    check("sim_aw_once", aw_rise, 1);
    check("sim_w_once", w_rise, 1);

    // Timeout in RD_ADDR: 8 cycles in the state, then SLVERR + timeout.
    issue(1'b0, 32'h40, 32'h0);
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("to_wait%0d", i), {rsp_valid, rdaddr_enb}, 2'b01);
    end
    tick();
    check("to_fire", {rsp_valid, rdaddr_enb}, 2'b10);
    push(32'h0, 2'b10, 1'b1);
    collect_rsp("to");

    // Handshake coinciding with expiry wins.
    issue(1'b0, 32'h50, 32'h0);
    repeat (7) tick();
    ar_hs();
    check("race_no_to", {rsp_valid, rdaddr_enb}, 2'b00);
    push(32'h0BAD_F00D, 2'b01, 1'b0);
    r_hs(32'h0BAD_F00D, 2'b01);
    collect_rsp("race");

    // Backpressure, then a queued write accepted one cycle after RSP exit.
    issue(1'b0, 32'h60, 32'h0);
    ar_hs();
    push(32'h1111_2222, 2'b00, 1'b0);
    r_hs(32'h1111_2222, 2'b00);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h70; cmd_wdata = 32'h55;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_hold%0d", i), {rsp_valid, cmd_ready}, 2'b10);
      check($sformatf("bp_data%0d", i), rsp_rdata, 32'h1111_2222);
      tick();
    end
    collect_rsp("bp");
    tick();
    cmd_valid = 1'b0;
    check("b2b_accept", {wraddr_enb, cmd_ready}, 2'b10);
    check("b2b_addr", mwrite_address, 32'h70);
    AWVALID = 1'b1; AwREADY = 1'b1; WVALID = 1'b1; WREADY = 1'b1;
    tick();
    {AWVALID, AwREADY, WVALID, WREADY} = '0;
    push(32'h0, 2'b11, 1'b0);
    b_hs(2'b11);
    collect_rsp("b2b");

    // Asynchronous reset while waiting in WR_RESP.
    issue(1'b1, 32'h80, 32'hCAFE_0000);
    AWVALID = 1'b1; AwREADY = 1'b1; WVALID = 1'b1; WREADY = 1'b1;
    tick();
    {AWVALID, AwREADY, WVALID, WREADY} = '0;
    #2 rst = 1'b0;
    #1;
    check("arst_cmd_ready", cmd_ready, 1);
    check("arst_outs", {rsp_valid, rdaddr_enb, wraddr_enb, wrdata_enb}, 0);
    check("arst_waddr", mwrite_address, 0);
    tick();
    rst = 1'b1;
    b_hs(2'b01);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("arst_idle%0d", i), {rsp_valid, cmd_ready}, 2'b01);
      tick();
    end
    check("sb_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
